// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM boundary signals for the execute stage.
// master: the side presenting the ID/EX register (decode stage or bench).
// slave : the execute stage itself.
interface ex_stage_if;
    // ID/EX pipeline register contents
    logic [1:0]  WB_ctl_in;
    logic [3:0]  MEM_ctl_in;
    logic [1:0]  ALUop;
    logic        ALUsrc;
    logic        RegDst;
    logic [31:0] pc_in;
    logic [31:0] RD1_in;
    logic [31:0] RD2_in;
    logic [31:0] immed_exted_in;
    logic [4:0]  Rt_in;
    logic [4:0]  Rd_in;
    logic [4:0]  shamt_in;

    // EX/MEM pipeline register contents
    logic [1:0]  WB_ctl_out;
    logic [3:0]  MEM_ctl_out;
    logic [31:0] alu_result;
    logic [31:0] branch_target;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  write_reg;

    // Front-of-pipeline hold request
    logic        stall;

    modport master (
        output WB_ctl_in, MEM_ctl_in, ALUop, ALUsrc, RegDst, pc_in,
               RD1_in, RD2_in, immed_exted_in, Rt_in, Rd_in, shamt_in,
        input  WB_ctl_out, MEM_ctl_out, alu_result, branch_target, zero,
               store_data, write_reg, stall
    );

    modport slave (
        input  WB_ctl_in, MEM_ctl_in, ALUop, ALUsrc, RegDst, pc_in,
               RD1_in, RD2_in, immed_exted_in, Rt_in, Rd_in, shamt_in,
        output WB_ctl_out, MEM_ctl_out, alu_result, branch_target, zero,
               store_data, write_reg, stall
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Computes ALU result, branch target and zero flag, registers them with the
// forwarded WB/MEM control bundles into EX/MEM. An iterative shift-add
// multiplier owns HI/LO and holds the front of the pipeline while it runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;

    // Multiplier state
    mul_state_t  mul_state_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // EX/MEM register
    logic [1:0]  wb_ctl_q,        wb_ctl_d;
    logic [3:0]  mem_ctl_q,       mem_ctl_d;
    logic [31:0] alu_result_q,    alu_result_d;
    logic [31:0] branch_target_q, branch_target_d;
    logic        zero_q,          zero_d;
    logic [31:0] store_data_q,    store_data_d;
    logic [4:0]  write_reg_q,     write_reg_d;

    logic [5:0]  funct;
    logic        is_rtype;
    logic        multu_in;
    logic [31:0] operand_b;
    logic [31:0] alu_value;
    logic        stall;

    assign funct     = bus.immed_exted_in[5:0];
    assign is_rtype  = (bus.ALUop == 2'b10);
    assign multu_in  = is_rtype && (funct == FUNCT_MULTU);
    assign operand_b = bus.ALUsrc ? bus.immed_exted_in : bus.RD2_in;

    // Hold the front of the pipeline while a multu is being accepted or iterated.
    // In DONE the multu is allowed to leave ID/EX so it is not restarted.
    assign stall = ((mul_state_q == MUL_IDLE) && multu_in) || (mul_state_q == MUL_BUSY);

    // ALU: direct ops from ALUop, R-type ops decoded from funct
    always_comb begin
        alu_value = 32'd0;
        case (bus.ALUop)
            2'b01: alu_value = bus.RD1_in - operand_b;
            2'b10: begin
                case (funct)
                    FUNCT_ADD:  alu_value = bus.RD1_in + operand_b;
                    FUNCT_SUB:  alu_value = bus.RD1_in - operand_b;
                    FUNCT_AND:  alu_value = bus.RD1_in & operand_b;
                    FUNCT_OR:   alu_value = bus.RD1_in | operand_b;
                    FUNCT_SLT:  alu_value = ($signed(bus.RD1_in) < $signed(operand_b)) ? 32'd1 : 32'd0;
                    FUNCT_SLL:  alu_value = bus.RD2_in << bus.shamt_in;
                    FUNCT_SRL:  alu_value = bus.RD2_in >> bus.shamt_in;
                    FUNCT_MFHI: alu_value = hi_q;
                    FUNCT_MFLO: alu_value = lo_q;
                    default:    alu_value = 32'd0;
                endcase
            end
            default: alu_value = bus.RD1_in + operand_b;  // 00 and 11 both add
        endcase
    end

    // Multiplier FSM: accept, 32 shift-add steps, then commit product to HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state_q <= MUL_IDLE;
            count_q     <= 5'd0;
            acc_q       <= 64'd0;
            mcand_q     <= 64'd0;
            mplier_q    <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            case (mul_state_q)
                MUL_IDLE: begin
                    if (multu_in) begin
                        mcand_q     <= {32'd0, bus.RD1_in};
                        mplier_q    <= bus.RD2_in;
                        acc_q       <= 64'd0;
                        count_q     <= 5'd0;
                        mul_state_q <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= {mcand_q[62:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[31:1]};
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        mul_state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    hi_q        <= acc_q[63:32];
                    lo_q        <= acc_q[31:0];
                    mul_state_q <= MUL_IDLE;
                end
                default: mul_state_q <= MUL_IDLE;
            endcase
        end
    end

    // Next EX/MEM contents: bubble while stalled, otherwise the current instruction
    always_comb begin
        wb_ctl_d        = wb_ctl_q;
        mem_ctl_d       = mem_ctl_q;
        alu_result_d    = alu_result_q;
        branch_target_d = branch_target_q;
        zero_d          = zero_q;
        store_data_d    = store_data_q;
        write_reg_d     = write_reg_q;
        if (stall) begin
            wb_ctl_d  = 2'b00;
            mem_ctl_d = 4'b0000;
        end else begin
            // multu writes no GPR, so its WB controls are suppressed on retire
            wb_ctl_d        = multu_in ? 2'b00 : bus.WB_ctl_in;
            mem_ctl_d       = bus.MEM_ctl_in;
            alu_result_d    = alu_value;
            branch_target_d = bus.pc_in + {bus.immed_exted_in[29:0], 2'b00};
            zero_d          = (alu_value == 32'd0);
            store_data_d    = bus.RD2_in;
            write_reg_d     = bus.RegDst ? bus.Rd_in : bus.Rt_in;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctl_q        <= 2'b00;
            mem_ctl_q       <= 4'b0000;
            alu_result_q    <= 32'd0;
            branch_target_q <= 32'd0;
            zero_q          <= 1'b0;
            store_data_q    <= 32'd0;
            write_reg_q     <= 5'd0;
        end else begin
            wb_ctl_q        <= wb_ctl_d;
            mem_ctl_q       <= mem_ctl_d;
            alu_result_q    <= alu_result_d;
            branch_target_q <= branch_target_d;
            zero_q          <= zero_d;
            store_data_q    <= store_data_d;
            write_reg_q     <= write_reg_d;
        end
    end

    assign bus.WB_ctl_out    = wb_ctl_q;
    assign bus.MEM_ctl_out   = mem_ctl_q;
    assign bus.alu_result    = alu_result_q;
    assign bus.branch_target = branch_target_q;
    assign bus.zero          = zero_q;
    assign bus.store_data    = store_data_q;
    assign bus.write_reg     = write_reg_q;
    assign bus.stall         = stall;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected stall/EX-MEM values,
// an independent monitor pops and compares them on the falling edge.
module tb_ex_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic        src;
        logic        dst;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [1:0]  wb;
        logic [3:0]  mem;
    } instr_t;

    typedef struct {
        int          cyc;
        logic [1:0]  wb;
        logic [3:0]  mem;
        logic [31:0] alu;
        logic [31:0] bt;
        logic        z;
        logic [31:0] sd;
        logic [4:0]  wr;
    } oexp_t;

    typedef struct {
        int   cyc;
        logic st;
    } sexp_t;

    sexp_t sq[$];
    oexp_t oq[$];

    int checks = 0;
    int fails  = 0;
    int scyc   = 0;
    int mcyc   = 0;

    // Reference model state: current EX/MEM contents and HI/LO
    oexp_t       m;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    function automatic instr_t mk(logic [1:0] op, logic src, logic dst, logic [31:0] pc,
                                  logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                                  logic [4:0] rt, logic [4:0] rd, logic [4:0] sh,
                                  logic [1:0] wb, logic [3:0] mem);
        instr_t t;
        t.op = op; t.src = src; t.dst = dst; t.pc = pc; t.rd1 = rd1; t.rd2 = rd2;
        t.imm = imm; t.rt = rt; t.rd = rd; t.sh = sh; t.wb = wb; t.mem = mem;
        return t;
    endfunction

    function automatic bit is_multu(instr_t t);
        return (t.op == 2'b10) && (t.imm[5:0] == 6'h19);
    endfunction

    // Architectural result of one instruction
    function automatic logic [31:0] model_alu(instr_t t);
        logic [31:0] b;
        b = t.src ? t.imm : t.rd2;
        if (t.op == 2'b01) return t.rd1 - b;
        if (t.op != 2'b10) return t.rd1 + b;
        case (t.imm[5:0])
            6'h20: return t.rd1 + b;
            6'h22: return t.rd1 - b;
            6'h24: return t.rd1 & b;
            6'h25: return t.rd1 | b;
            6'h2A: return ($signed(t.rd1) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: return t.rd2 << t.sh;
            6'h02: return t.rd2 >> t.sh;
            6'h10: return m_hi;
            6'h12: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        logic [5:0] functs [10];
        instr_t t;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h10, 6'h12, 6'h3F};
        t.op  = 2'($urandom_range(0, 3));
        t.src = 1'($urandom_range(0, 1));
        t.dst = 1'($urandom_range(0, 1));
        t.pc  = $urandom;
        t.rd1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        t.rd2 = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
        t.imm = $urandom;
        if (t.op == 2'b10) begin
            t.src = 1'b0;
            t.imm[5:0] = functs[$urandom_range(0, 9)];
        end
        t.rt  = 5'($urandom);
        t.rd  = 5'($urandom);
        t.sh  = 5'($urandom);
        t.wb  = 2'($urandom);
        t.mem = 4'($urandom);
        return t;
    endfunction

    task automatic drive(instr_t t, logic r);
        @(posedge clk);
        #1;
        rst                = r;
        bus.ALUop          = t.op;
        bus.ALUsrc         = t.src;
        bus.RegDst         = t.dst;
        bus.pc_in          = t.pc;
        bus.RD1_in         = t.rd1;
        bus.RD2_in         = t.rd2;
        bus.immed_exted_in = t.imm;
        bus.Rt_in          = t.rt;
        bus.Rd_in          = t.rd;
        bus.shamt_in       = t.sh;
        bus.WB_ctl_in      = t.wb;
        bus.MEM_ctl_in     = t.mem;
        scyc++;
    endtask

    // Expected stall for this cycle, expected EX/MEM after the coming edge
    task automatic push(logic st);
        sexp_t s;
        oexp_t e;
        s.cyc = scyc;
        s.st  = st;
        sq.push_back(s);
        e = m;
        e.cyc = scyc + 1;
        oq.push_back(e);
    endtask

    task automatic retire(instr_t t, bit wb_zero);
        m.alu = model_alu(t);
        m.wb  = wb_zero ? 2'b00 : t.wb;
        m.mem = t.mem;
        m.bt  = t.pc + (t.imm << 2);
        m.z   = (m.alu == 32'd0);
        m.sd  = t.rd2;
        m.wr  = t.dst ? t.rd : t.rt;
    endtask

    task automatic bubble();
        m.wb  = 2'b00;
        m.mem = 4'b0000;
    endtask

    task automatic issue(instr_t t);
        logic [63:0] p;
        if (is_multu(t)) begin
            repeat (33) begin
                drive(t, 1'b0);
                bubble();
                push(1'b1);
            end
            drive(t, 1'b0);
            retire(t, 1'b1);
            p = 64'(t.rd1) * 64'(t.rd2);
            m_hi = p[63:32];
            m_lo = p[31:0];
            push(1'b0);
        end else begin
            drive(t, 1'b0);
            retire(t, 1'b0);
            push(1'b0);
        end
    endtask

    // multu interrupted by reset while the step counter is at 10
    task automatic reset_mid_multu(instr_t t);
        repeat (11) begin
            drive(t, 1'b0);
            bubble();
            push(1'b1);
        end
        drive(t, 1'b1);
        m    = '{default: 0};
        m_hi = 32'd0;
        m_lo = 32'd0;
        push(1'b1);
    endtask

    // Monitor: independent cycle count, compares whatever is due this cycle
    always @(posedge clk) mcyc <= mcyc + 1;

    always @(negedge clk) begin
        if (sq.size() > 0 && sq[0].cyc == mcyc) begin
            sexp_t s;
            s = sq.pop_front();
            checks++;
            if (bus.stall !== s.st) begin
                fails++;
                $display("FAIL stall cyc=%0d got=%0b exp=%0b", mcyc, bus.stall, s.st);
            end
        end
        if (oq.size() > 0 && oq[0].cyc == mcyc) begin
            oexp_t e;
            e = oq.pop_front();
            checks++;
            if (bus.WB_ctl_out !== e.wb || bus.MEM_ctl_out !== e.mem ||
                bus.alu_result !== e.alu || bus.branch_target !== e.bt ||
                bus.zero !== e.z || bus.store_data !== e.sd || bus.write_reg !== e.wr) begin
                fails++;
                $display("FAIL exmem cyc=%0d got wb=%h mem=%h alu=%h bt=%h z=%b sd=%h wr=%0d exp wb=%h mem=%h alu=%h bt=%h z=%b sd=%h wr=%0d",
                         mcyc, bus.WB_ctl_out, bus.MEM_ctl_out, bus.alu_result, bus.branch_target,
                         bus.zero, bus.store_data, bus.write_reg,
                         e.wb, e.mem, e.alu, e.bt, e.z, e.sd, e.wr);
            end else begin
                $display("txn cyc=%0d wb=%h mem=%h alu=%h bt=%h z=%b wr=%0d",
                         mcyc, e.wb, e.mem, e.alu, e.bt, e.z, e.wr);
            end
        end
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout sim time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t nop;
        nop  = mk(2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 2'b00, 4'h0);
        m    = '{default: 0};
        m_hi = 32'd0;
        m_lo = 32'd0;

        // Reset: first cycle unchecked, second cycle checks the reset state
        drive(nop, 1'b1);
        drive(nop, 1'b1);
        push(1'b0);

        // add via funct 0x20
        issue(mk(2'b10, 1'b0, 1'b1, 32'h10, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3, 5'd0, 2'b10, 4'h0));
        // address add with negative immediate
        issue(mk(2'b00, 1'b1, 1'b0, 32'h20, 32'h100, 32'h1234, 32'hFFFFFFFC, 5'd6, 5'd7, 5'd0, 2'b11, 4'h5));
        // branch compare and target
        issue(mk(2'b01, 1'b0, 1'b0, 32'h40, 32'h55, 32'h55, 32'd3, 5'd1, 5'd2, 5'd0, 2'b00, 4'h8));
        // branch target carry wraps
        issue(mk(2'b01, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h1, 32'h2, 32'h8, 5'd1, 5'd2, 5'd0, 2'b00, 4'h8));
        // sll and slt
        issue(mk(2'b10, 1'b0, 1'b1, 32'h50, 32'd0, 32'd1, 32'h00, 5'd0, 5'd4, 5'd4, 2'b10, 4'h0));
        issue(mk(2'b10, 1'b0, 1'b1, 32'h54, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd0, 5'd5, 5'd0, 2'b10, 4'h0));
        // multu 0xFFFFFFFF^2 then mfhi / mflo
        issue(mk(2'b10, 1'b0, 1'b1, 32'h58, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h19, 5'd0, 5'd0, 5'd0, 2'b10, 4'h3));
        issue(mk(2'b10, 1'b0, 1'b1, 32'h5C, 32'd0, 32'd0, 32'h10, 5'd0, 5'd8, 5'd0, 2'b10, 4'h0));
        issue(mk(2'b10, 1'b0, 1'b1, 32'h60, 32'd0, 32'd0, 32'h12, 5'd0, 5'd9, 5'd0, 2'b10, 4'h0));

        // Randomized traffic with occasional random multu
        for (int i = 0; i < 150; i++) begin
            if (i % 50 == 25) begin
                instr_t mt;
                mt = rand_instr();
                mt.op  = 2'b10;
                mt.src = 1'b0;
                mt.imm[5:0] = 6'h19;
                issue(mt);
            end
            issue(rand_instr());
        end

        // Reset in the middle of a multiply, then mfhi must read the cleared HI
        issue(mk(2'b10, 1'b0, 1'b1, 32'h70, 32'hDEADBEEF, 32'h12345678, 32'h19, 5'd0, 5'd0, 5'd0, 2'b10, 4'h0));
        issue(mk(2'b10, 1'b0, 1'b1, 32'h74, 32'd0, 32'd0, 32'h10, 5'd0, 5'd8, 5'd0, 2'b10, 4'h0));
        reset_mid_multu(mk(2'b10, 1'b0, 1'b1, 32'h78, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h19, 5'd0, 5'd0, 5'd0, 2'b10, 4'h2));
        issue(mk(2'b10, 1'b0, 1'b1, 32'h7C, 32'd0, 32'd0, 32'h10, 5'd0, 5'd8, 5'd0, 2'b10, 4'h0));
        issue(mk(2'b10, 1'b0, 1'b1, 32'h80, 32'd0, 32'd0, 32'h12, 5'd0, 5'd9, 5'd0, 2'b10, 4'h0));

        // Drain, then confirm every expectation was consumed
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sq.size() != 0 || oq.size() != 0) begin
            fails++;
            $display("FAIL drain pending stall=%0d exmem=%0d required 0", sq.size(), oq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
